// File: rtl/carrier_pwm_if.sv
// carrier_pwm_if: write port carrying the carrier period value and its acknowledge
interface carrier_pwm_if #(parameter int PWM_BITS = 8);
  logic                wr_strobe_in;
  logic [PWM_BITS-1:0] value_in;
  logic                wr_ack_out;
  modport master(output wr_strobe_in, value_in, input wr_ack_out);
  modport slave(input wr_strobe_in, value_in, output wr_ack_out);
endinterface

// File: rtl/carrier_pwm.sv
// carrier_pwm: 50% duty IR carrier generator; PWM_SYNC_UPDATE_EN defers period updates to the wrap cycle
module carrier_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic               clock_in,
  input  logic               reset_in,
  input  logic               enable_in,
  input  logic               forced_in,
  carrier_pwm_if.slave       wr,
  output logic               pwm_out,
  output logic               period_tick_out
);
  logic [PWM_BITS-1:0] period_q, period_d, pending_q, pending_d, counter_q, counter_d;
  logic                update_pending_q, update_pending_d;
  logic                pwm_q, pwm_d, tick_q, tick_d, ack_q, ack_d;
  logic                wrap, apply;
  logic [PWM_BITS:0]   half;
  always_comb begin
    wrap = counter_q == period_q;
`ifdef PWM_SYNC_UPDATE_EN
    apply = update_pending_q && (!enable_in || wrap);
`else
    apply = update_pending_q;
`endif
    half = ({1'b0, period_q} + 1'b1) >> 1;
    period_d = apply ? pending_q : period_q;
    pending_d = wr.wr_strobe_in ? wr.value_in : pending_q;
    // a strobe coinciding with an update keeps the flag set for the newer value
    update_pending_d = wr.wr_strobe_in | (update_pending_q & ~apply);
    counter_d = (!enable_in || wrap || apply) ? '0 : counter_q + 1'b1;
    pwm_d = forced_in | (enable_in & ({1'b0, counter_q} < half));
    tick_d = enable_in & wrap;
    ack_d = wr.wr_strobe_in;
  end
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      period_q <= '0;
      pending_q <= '0;
      counter_q <= '0;
      update_pending_q <= 1'b0;
      pwm_q <= 1'b0;
      tick_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      period_q <= period_d;
      pending_q <= pending_d;
      counter_q <= counter_d;
      update_pending_q <= update_pending_d;
      pwm_q <= pwm_d;
      tick_q <= tick_d;
      ack_q <= ack_d;
    end
  end
  assign pwm_out = pwm_q;
  assign period_tick_out = tick_q;
  assign wr.wr_ack_out = ack_q;
endmodule

// File: doc/carrier_pwm.md
CARRIER_PWM -- requirements
Module: carrier_pwm

Interface
REQ-001 Parameter: PWM_BITS, default 8, width of the carrier period value.
REQ-002 clock_in  input  1  single clock; all logic on its rising edge.
REQ-003 reset_in  input  1  reset; synchronous, active-high.
REQ-004 enable_in  input  1  carrier generation runs while high.
REQ-005 forced_in  input  1  output held high (unmodulated) while high.
REQ-006 wr_strobe_in  input  1  write request for value_in.
REQ-007 value_in  input  PWM_BITS  carrier period minus one, in clocks.
REQ-008 wr_ack_out  output  1  write accepted, one-cycle pulse.
REQ-009 pwm_out  output  1  registered carrier output to the IR driver.
REQ-010 period_tick_out  output  1  one-cycle pulse on the last clock of each carrier period.

Function
REQ-011 Internal registers SHALL be: period_r, pending_r, update_pending_r (1 bit) and counter_r (PWM_BITS bits).
REQ-012 A cycle with wr_strobe_in high SHALL load value_in into pending_r, set update_pending_r, and pulse wr_ack_out in the next cycle; every strobe-high cycle is a separate write.
REQ-013 While enable_in is low, counter_r SHALL be held at 0, and any pending value SHALL be moved into period_r in the next cycle.
REQ-014 While enable_in is high, counter_r SHALL count 0..period_r and then wrap to 0, giving a period of period_r+1 clocks.
REQ-015 The carrier level SHALL be high when counter_r < ((period_r+1)>>1), with the sum computed at PWM_BITS+1 bits; otherwise it is low.
REQ-016 period_r=0 SHALL yield a constant low carrier, with period_tick_out high every enabled cycle.
REQ-017 pwm_out SHALL be registered: pwm_out(n+1) = forced_in(n) OR (enable_in(n) AND carrier(n)); forced_in takes priority over enable_in.
REQ-018 period_tick_out(n+1) SHALL equal enable_in(n) AND (counter_r(n)==period_r(n)).
REQ-019 On the first enabled cycle after enable_in rises, counter_r SHALL be 0, so pwm_out goes high one cycle later when period_r >= 1.
REQ-020 A write in the same cycle as an update SHALL win: the new value goes to pending_r and update_pending_r stays set.
REQ-021 A write while enable_in is low SHALL take effect in period_r no later than the cycle after the strobe.

Reset
REQ-022 With reset_in high at a clock edge, period_r, pending_r, counter_r and update_pending_r SHALL be 0, and pwm_out, wr_ack_out and period_tick_out SHALL be 0 in the next cycle.
REQ-023 reset_in SHALL override every other input, including a strobe in the same cycle, which is then not acknowledged.
REQ-024 Reset mid-period SHALL discard the period and any pending write.

Configuration
REQ-025 Macro PWM_SYNC_UPDATE_EN SHALL select how a new value is applied while enabled.
REQ-026 When defined: while enabled, pending_r SHALL move to period_r only on a wrap cycle (counter_r==period_r), so no truncated carrier period occurs.
REQ-027 When undefined: pending_r SHALL move to period_r in the cycle after the strobe, and counter_r SHALL restart at 0 that same cycle.

Verification
REQ-028 Reset then idle: pwm_out, wr_ack_out and period_tick_out all 0 for 20 cycles.
REQ-029 Write 3 with a one-cycle strobe, then enable: wr_ack_out pulses once; pwm_out repeats 1,1,0,0 with period 4; period_tick_out pulses every 4th cycle.
REQ-030 Enabled at value 9, write 5 at counter 2: with PWM_SYNC_UPDATE_EN, the 10-cycle period completes before 6-cycle periods begin; without it, the counter restarts and 6-cycle periods start immediately.
REQ-031 forced_in high with enable_in low, then with enable_in high: pwm_out constant 1 in both cases; forced_in low with enable_in low: pwm_out 0 one cycle later.
REQ-032 Write 0, then enable: pwm_out stays 0 and period_tick_out is high every cycle.
REQ-033 reset_in asserted mid-period with a strobe in the same cycle: no ack, and all outputs are 0 in the next cycle.
